dbus_responder: RTL and testbench

- Data-bus target that answers the core's dbus_req_t requests with dbus_resp_t responses.
- Backed by a local 64-bit-word scratchpad RAM.
- Sits on the far side of the core's memory-stage port, in place of the simulation bus.
- Lets the pipeline's stall handshake (valid held until data_ok) run under programmable latency, in simulation and in synthesis.

---
 rtl/dbus_responder.sv | 92 +++++++++
 tb/tb_dbus_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dbus_responder.sv
// dbus_responder: data-bus target over a 64-bit-word scratchpad with programmable response latency.
// Define DBUS_RESP_STALL_INJECT_EN to add 0..3 pseudo-random extra wait cycles per request.
module dbus_responder #(
  parameter int          MEM_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dreq_valid_i,
  input  logic [63:0] dreq_addr_i,
  input  logic [2:0]  dreq_size_i,
  input  logic [7:0]  dreq_strobe_i,
  input  logic [63:0] dreq_data_i,
  output logic        dresp_addr_ok_o,
  output logic        dresp_data_ok_o,
  output logic [63:0] dresp_data_o,
  output logic        err
);
  localparam int IW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d, extra, total;
  logic [63:0] addr_q, data_q, off;
  logic [7:0] strobe_q;
  logic write_q, err_q, oor, accept, unused_size;
  logic [IW-1:0] idx;
  logic [63:0] mem [MEM_WORDS];
  assign unused_size = ^dreq_size_i;
  assign accept = state_q == IDLE && dreq_valid_i;
  assign off = addr_q - BASE_ADDR;
  assign oor = (addr_q < BASE_ADDR) || ((off >> 3) >= 64'(MEM_WORDS));
  assign idx = off[IW+2:3];
  assign total = 5'(LATENCY) + extra;
  assign err = err_q;
`ifdef DBUS_RESP_STALL_INJECT_EN
  logic [7:0] lfsr_q;
  assign extra = {3'd0, lfsr_q[1:0]};
  always_ff @(posedge clk or negedge reset)
    if (!reset) lfsr_q <= 8'hA5;
    else if (accept) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`else
  assign extra = 5'd0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | (state_q == RESP && oor);
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      addr_q   <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      write_q  <= 1'b0;
    end else if (accept) begin
      addr_q   <= dreq_addr_i;
      data_q   <= dreq_data_i;
      strobe_q <= dreq_strobe_i;
      write_q  <= |dreq_strobe_i;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (dreq_valid_i) begin
        cnt_d   = total - 5'd1;
        state_d = total > 5'd1 ? WAIT : RESP;
      end
      WAIT: begin
        cnt_d   = cnt_q - 5'd1;
        state_d = cnt_q == 5'd1 ? RESP : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  // the response reads the old word; the merged write lands on the closing edge of RESP
  always_ff @(posedge clk)
    if (state_q == RESP && write_q && !oor)
      for (int b = 0; b < 8; b++)
        if (strobe_q[b]) mem[idx][8*b +: 8] <= data_q[8*b +: 8];
  always_comb begin
    dresp_addr_ok_o = reset && accept;
    dresp_data_ok_o = state_q == RESP;
    dresp_data_o    = (state_q == RESP && !oor) ? mem[idx] : '0;
  end
endmodule

// File: tb/tb_dbus_responder.sv
// tb_dbus_responder: random traffic against a word-array model, scoreboard checks data, timing and err.
module tb_dbus_responder;
  localparam int          MW   = 4096;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          LAT  = 2;
  logic clk = 0, reset = 0;
  logic dreq_valid = 0;
  logic [63:0] dreq_addr = 0, dreq_data = 0;
  logic [2:0] dreq_size = 0;
  logic [7:0] dreq_strobe = 0;
  logic dresp_addr_ok, dresp_data_ok, err;
  logic [63:0] dresp_data;
  dbus_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .dreq_valid_i(dreq_valid), .dreq_addr_i(dreq_addr), .dreq_size_i(dreq_size),
    .dreq_strobe_i(dreq_strobe), .dreq_data_i(dreq_data),
    .dresp_addr_ok_o(dresp_addr_ok), .dresp_data_ok_o(dresp_data_ok),
    .dresp_data_o(dresp_data), .err(err)
  );
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {logic [63:0] data; int unsigned due; bit oor; bit known;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  logic [63:0] mdl [int];
  logic exp_err = 0;
  logic [7:0] lfsr_m = 8'hA5;
  int checks = 0, fails = 0;
  logic [63:0] pool [10] = '{BASE, BASE + 8, BASE + 16, BASE + 24, BASE + 32, BASE + 800,
                             BASE + 8 * 2047, BASE + 8 * 4094, BASE + 8 * 4095, BASE + 8 * 3};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int next_lat();
    int e;
    e = 0;
`ifdef DBUS_RESP_STALL_INJECT_EN
    e = int'(lfsr_m[1:0]);
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
    return LAT + e;
  endfunction

  always @(negedge clk) begin
    #2;
    if (reset) begin
      if (dresp_data_ok) begin
        if (sbq.size() == 0) chk("unexpected_data_ok", 1, 0);
        else begin
          mon_e = sbq.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(mon_e.due));
          if (mon_e.known) chk("resp_data", dresp_data, mon_e.data);
          chk("err_at_resp", 64'(err), 64'(exp_err));
          exp_err = exp_err | mon_e.oor;
        end
      end else begin
        chk("data_zero_outside_resp", dresp_data, 0);
        if (sbq.size() != 0 && cyc > sbq[0].due) begin
          chk("missing_data_ok", 0, 1);
          void'(sbq.pop_front());
        end
      end
    end
  end

  // called at the falling edge of an IDLE cycle; returns at the falling edge of the next IDLE cycle
  task automatic issue(logic [63:0] a, logic [7:0] s, logic [63:0] d, bit hold);
    exp_t e;
    int lat, idx;
    logic [63:0] w;
    dreq_valid = 1; dreq_addr = a; dreq_strobe = s; dreq_data = d; dreq_size = 3'($urandom);
    #1 chk("addr_ok_accept", 64'(dresp_addr_ok), 1);
    lat = next_lat();
    e.oor = (a < BASE) || (((a - BASE) >> 3) >= 64'(MW));
    idx = e.oor ? 0 : int'((a - BASE) >> 3);
    e.known = e.oor || mdl.exists(idx);
    e.data = e.oor ? 64'd0 : (e.known ? mdl[idx] : 64'd0);
    e.due = cyc + lat;
    sbq.push_back(e);
    if (!e.oor && s != 0) begin
      w = e.known ? mdl[idx] : 64'd0;
      for (int b = 0; b < 8; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      mdl[idx] = w;
    end
    @(negedge clk);
    if (hold) begin
      dreq_addr = {$urandom, $urandom}; dreq_strobe = 8'($urandom); dreq_data = {$urandom, $urandom};
      #1 chk("addr_ok_busy", 64'(dresp_addr_ok), 0);
    end else dreq_valid = 0;
    repeat (lat) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 0; dreq_valid = 1; dreq_addr = BASE;
    @(negedge clk);
    #1;
    chk("rst_addr_ok", 64'(dresp_addr_ok), 0);
    chk("rst_data_ok", 64'(dresp_data_ok), 0);
    chk("rst_data", dresp_data, 0);
    chk("rst_err", 64'(err), 0);
    dreq_valid = 0;
    sbq.delete(); exp_err = 0; lfsr_m = 8'hA5;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    logic [7:0] s;
    int r;
    do_reset();
    issue(BASE + 64'h10, 8'hFF, 64'h1122_3344_5566_7788, 0);
    issue(BASE + 64'h10, 8'h00, 64'h0, 0);
    issue(BASE + 64'h12, 8'h04, 64'h0000_0000_00AB_0000, 0);
    issue(BASE + 64'h10, 8'h00, 64'h0, 0);
    foreach (pool[i]) if (pool[i] != BASE + 64'h10) issue(pool[i], 8'hFF, {$urandom, $urandom}, 0);
    issue(64'h7FFF_FFF8, 8'h00, 64'h0, 0);
    issue(BASE + 64'(8 * MW), 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 0);
    issue(BASE, 8'h00, 64'h0, 0);
    issue(BASE + 8, 8'hFF, 64'h0123_4567_89AB_CDEF, 1);
    issue(BASE + 8, 8'h00, 64'h0, 1);
    issue(BASE + 24, 8'h00, 64'h0, 0);
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 19);
      a = r == 0 ? BASE - 64'(8 * $urandom_range(1, 4)) :
          r == 1 ? BASE + 64'(8 * MW) + 64'($urandom_range(0, 31)) :
          pool[$urandom_range(0, 9)] + 64'($urandom_range(0, 7));
      s = $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom);
      issue(a, s, {$urandom, $urandom}, i < 199 && $urandom_range(0, 3) == 0);
    end
    dreq_valid = 1; dreq_addr = BASE + 32; dreq_strobe = 8'hFF; dreq_data = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    dreq_valid = 0;
    #1 reset = 0;
    #1;
    chk("abort_data_ok", 64'(dresp_data_ok), 0);
    chk("abort_data", dresp_data, 0);
    chk("abort_err", 64'(err), 0);
    repeat (2) @(negedge clk);
    reset = 1; sbq.delete(); exp_err = 0; lfsr_m = 8'hA5;
    @(negedge clk);
    issue(BASE + 32, 8'h00, 64'h0, 0);
    for (int i = 0; i < 16; i++) issue(pool[i % 10], 8'h00, 64'h0, 0);
    repeat (4) @(negedge clk);
    #3;
    chk("scoreboard_drained", 64'(sbq.size()), 0);
    chk("err_final", 64'(err), 64'(exp_err));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
